// File: rtl/ahb_sdr_pattern_master.sv
// ---------------------------------------------------------------------------
// ahb_sdr_pattern_master
//
// AHB-Lite initiator used as a memory self-test. A START pulse runs one pass:
//   1. Write P(i) = (BASE_ADDR + 4*i) ^ SEED to NUM_WORDS consecutive words.
//   2. Read the same words back and compare each one against P(i).
// It then reports DONE/PASS, the number of mismatches and the first failing
// address. An ERROR response aborts the test and sets BUS_ERR.
//
// Ports
//   HCLK, HRESETN            clock, asynchronous active-low reset
//   START                    one-cycle start pulse (ignored while busy)
//   HADDR/HTRANS/HSIZE/
//   HBURST/HWRITE/HWDATA     AHB-Lite master outputs
//                            (SINGLE, word-sized transfers only)
//   HRDATA/HREADY/HRESP      AHB-Lite slave responses
//   BUSY, DONE, PASS,
//   BUS_ERR, ERR_COUNT,
//   FAIL_ADDR                test status
// ---------------------------------------------------------------------------
module ahb_sdr_pattern_master #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          NUM_WORDS = 1024,
  parameter logic [31:0] SEED      = 32'hA5A5_0001
) (
  input  logic        HCLK,
  input  logic        HRESETN,
  input  logic        START,
  output logic [31:0] HADDR,
  output logic [1:0]  HTRANS,
  output logic [2:0]  HSIZE,
  output logic [2:0]  HBURST,
  output logic        HWRITE,
  output logic [31:0] HWDATA,
  input  logic [31:0] HRDATA,
  input  logic        HREADY,
  input  logic [1:0]  HRESP,
  output logic        BUSY,
  output logic        DONE,
  output logic        PASS,
  output logic        BUS_ERR,
  output logic [15:0] ERR_COUNT,
  output logic [31:0] FAIL_ADDR
);

  localparam logic [1:0]  TR_IDLE   = 2'b00;
  localparam logic [1:0]  TR_NONSEQ = 2'b10;
  localparam logic [1:0]  RSP_OKAY  = 2'b00;
  localparam logic [1:0]  RSP_ERROR = 2'b01;
  localparam logic [15:0] LAST_IDX  = 16'(NUM_WORDS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_WRITE, S_WDRAIN, S_READ, S_RDRAIN, S_FIN
  } state_t;

  state_t      state_q;
  logic [15:0] idx_q;       // word index of the current address phase
  logic [15:0] dp_idx_q;    // word index of the current data phase
  logic        dp_valid_q;  // a data phase is in flight
  logic [31:0] haddr_q;
  logic [1:0]  htrans_q;
  logic        hwrite_q;
  logic [31:0] hwdata_q;
  logic        busy_q;
  logic        done_q;
  logic        pass_q;
  logic        bus_err_q;
  logic [15:0] err_count_q;
  logic [31:0] fail_addr_q;

  function automatic logic [31:0] word_addr(input logic [15:0] idx);
    return BASE_ADDR + {14'd0, idx, 2'b00};
  endfunction

  function automatic logic [31:0] pattern(input logic [15:0] idx);
    return word_addr(idx) ^ SEED;
  endfunction

  logic data_done;  // current data phase completes this cycle
  logic bus_error;  // second cycle of an ERROR response on our data phase
  logic compare_en;
  logic mismatch;

  always_comb begin
    data_done  = HREADY && dp_valid_q;
    bus_error  = data_done && (HRESP == RSP_ERROR);
    compare_en = data_done && (HRESP == RSP_OKAY) &&
                 ((state_q == S_READ) || (state_q == S_RDRAIN));
    mismatch   = compare_en && (HRDATA != pattern(dp_idx_q));
  end

  always_ff @(posedge HCLK or negedge HRESETN) begin
    if (!HRESETN) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      dp_idx_q    <= '0;
      dp_valid_q  <= 1'b0;
      haddr_q     <= '0;
      htrans_q    <= TR_IDLE;
      hwrite_q    <= 1'b0;
      hwdata_q    <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      bus_err_q   <= 1'b0;
      err_count_q <= '0;
      fail_addr_q <= '0;
    end else begin
      // First ERROR cycle: the pending address is already masked on HTRANS;
      // keep it cancelled for the second cycle too.
      if (!HREADY && (HRESP == RSP_ERROR)) begin
        htrans_q <= TR_IDLE;
      end

      if (mismatch) begin
        if (err_count_q != 16'hFFFF) begin
          err_count_q <= err_count_q + 16'd1;
        end
        if (err_count_q == 16'd0) begin
          fail_addr_q <= word_addr(dp_idx_q);
        end
      end

      case (state_q)
        S_IDLE: begin
          if (START) begin
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            bus_err_q   <= 1'b0;
            err_count_q <= '0;
            fail_addr_q <= '0;
            busy_q      <= 1'b1;
            idx_q       <= '0;
            dp_valid_q  <= 1'b0;
            haddr_q     <= word_addr(16'd0);
            htrans_q    <= TR_NONSEQ;
            hwrite_q    <= 1'b1;
            state_q     <= S_WRITE;
          end
        end

        S_WRITE, S_READ: begin
          if (bus_error) begin
            bus_err_q  <= 1'b1;
            htrans_q   <= TR_IDLE;
            dp_valid_q <= 1'b0;
            state_q    <= S_FIN;
          end else if (HREADY && (htrans_q == TR_NONSEQ)) begin
            // Address phase accepted: it becomes the next data phase.
            dp_valid_q <= 1'b1;
            dp_idx_q   <= idx_q;
            if (state_q == S_WRITE) begin
              hwdata_q <= pattern(idx_q);
            end
            if (idx_q == LAST_IDX) begin
              htrans_q <= TR_IDLE;
              state_q  <= (state_q == S_WRITE) ? S_WDRAIN : S_RDRAIN;
            end else begin
              idx_q   <= idx_q + 16'd1;
              haddr_q <= word_addr(idx_q + 16'd1);
            end
          end
        end

        S_WDRAIN: begin
          if (bus_error) begin
            bus_err_q  <= 1'b1;
            dp_valid_q <= 1'b0;
            state_q    <= S_FIN;
          end else if (HREADY) begin
            dp_valid_q <= 1'b0;
            idx_q      <= '0;
            haddr_q    <= word_addr(16'd0);
            htrans_q   <= TR_NONSEQ;
            hwrite_q   <= 1'b0;
            state_q    <= S_READ;
          end
        end

        S_RDRAIN: begin
          if (bus_error) begin
            bus_err_q  <= 1'b1;
            dp_valid_q <= 1'b0;
            state_q    <= S_FIN;
          end else if (HREADY) begin
            dp_valid_q <= 1'b0;
            state_q    <= S_FIN;
          end
        end

        S_FIN: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          pass_q  <= (err_count_q == 16'd0) && !bus_err_q;
          state_q <= S_IDLE;
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  // HTRANS must drop to IDLE within the first ERROR cycle, before any clock
  // edge can update the register.
  assign HTRANS    = (!HREADY && (HRESP == RSP_ERROR)) ? TR_IDLE : htrans_q;
  assign HADDR     = haddr_q;
  assign HSIZE     = 3'b010;
  assign HBURST    = 3'b000;
  assign HWRITE    = hwrite_q;
  assign HWDATA    = hwdata_q;
  assign BUSY      = busy_q;
  assign DONE      = done_q;
  assign PASS      = pass_q;
  assign BUS_ERR   = bus_err_q;
  assign ERR_COUNT = err_count_q;
  assign FAIL_ADDR = fail_addr_q;

endmodule

// File: tb/tb_ahb_sdr_pattern_master.sv
// ---------------------------------------------------------------------------
// tb_ahb_sdr_pattern_master
//
// Directed bench for ahb_sdr_pattern_master (NUM_WORDS=4, BASE=0). A small
// AHB slave model with configurable wait states, read corruption and an
// ERROR response on one address provides the memory.
// ---------------------------------------------------------------------------
module tb_ahb_sdr_pattern_master;

  localparam int NW = 4;

  logic        HCLK = 1'b0;
  logic        HRESETN = 1'b0;
  logic        START = 1'b0;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic        HWRITE;
  logic [31:0] HWDATA;
  logic [31:0] HRDATA;
  logic        HREADY;
  logic [1:0]  HRESP;
  logic        BUSY;
  logic        DONE;
  logic        PASS;
  logic        BUS_ERR;
  logic [15:0] ERR_COUNT;
  logic [31:0] FAIL_ADDR;

  always #5 HCLK = ~HCLK;

  ahb_sdr_pattern_master #(
    .BASE_ADDR (32'h0000_0000),
    .NUM_WORDS (NW),
    .SEED      (32'hA5A5_0001)
  ) dut (
    .HCLK      (HCLK),
    .HRESETN   (HRESETN),
    .START     (START),
    .HADDR     (HADDR),
    .HTRANS    (HTRANS),
    .HSIZE     (HSIZE),
    .HBURST    (HBURST),
    .HWRITE    (HWRITE),
    .HWDATA    (HWDATA),
    .HRDATA    (HRDATA),
    .HREADY    (HREADY),
    .HRESP     (HRESP),
    .BUSY      (BUSY),
    .DONE      (DONE),
    .PASS      (PASS),
    .BUS_ERR   (BUS_ERR),
    .ERR_COUNT (ERR_COUNT),
    .FAIL_ADDR (FAIL_ADDR)
  );

  // ---------------- slave model configuration ----------------
  int          wait_states  = 0;
  logic [15:0] corrupt_mask = '0;  // bit n: corrupt reads of word n
  logic        err_en       = 1'b0;
  logic [31:0] err_addr     = '0;

  // ---------------- slave model state and logs ----------------
  logic        dp_act;
  logic        dp_wr;
  logic [31:0] dp_addr;
  int          wcnt;
  logic [31:0] mem [16];
  logic [31:0] log_addr [256];
  logic        log_wr   [256];
  int          log_cyc  [256];
  int          log_n = 0;
  logic [31:0] wd_log   [256];
  int          wd_n = 0;
  int          cyc = 0;

  always @(posedge HCLK or negedge HRESETN) begin
    if (!HRESETN) begin
      HREADY  <= 1'b1;
      HRESP   <= 2'b00;
      HRDATA  <= '0;
      dp_act  <= 1'b0;
      dp_wr   <= 1'b0;
      dp_addr <= '0;
      wcnt    <= 0;
    end else begin
      cyc <= cyc + 1;
      if (HREADY) begin
        if (dp_act && dp_wr && (HRESP == 2'b00)) begin
          mem[dp_addr[5:2]] <= HWDATA;
          wd_log[wd_n % 256] <= HWDATA;
          wd_n <= wd_n + 1;
        end
        if (HTRANS == 2'b10) begin
          log_addr[log_n % 256] <= HADDR;
          log_wr[log_n % 256]   <= HWRITE;
          log_cyc[log_n % 256]  <= cyc;
          log_n   <= log_n + 1;
          dp_act  <= 1'b1;
          dp_addr <= HADDR;
          dp_wr   <= HWRITE;
          HRDATA  <= mem[HADDR[5:2]] ^ (corrupt_mask[HADDR[5:2]] ? 32'h1 : 32'h0);
          if (err_en && (HADDR == err_addr)) begin
            HREADY <= 1'b0;
            HRESP  <= 2'b01;
          end else if (wait_states > 0) begin
            HREADY <= 1'b0;
            HRESP  <= 2'b00;
            wcnt   <= wait_states;
          end else begin
            HREADY <= 1'b1;
            HRESP  <= 2'b00;
          end
        end else begin
          dp_act <= 1'b0;
          HREADY <= 1'b1;
          HRESP  <= 2'b00;
        end
      end else begin
        if (HRESP == 2'b01) HREADY <= 1'b1;
        else if (wcnt > 1)  wcnt <= wcnt - 1;
        else                HREADY <= 1'b1;
      end
    end
  end

  // ---------------- output monitor (negedge) ----------------
  logic        chk_stable = 1'b0;
  int          stab_viol = 0;
  int          err_seen = 0;
  logic [1:0]  err_htrans = 2'b11;
  logic        prev_hready = 1'b1;
  logic [31:0] prev_haddr = '0;
  logic [1:0]  prev_htrans = '0;
  logic [31:0] prev_hwdata = '0;

  always @(negedge HCLK) begin
    if (chk_stable && HRESETN && !prev_hready) begin
      if (HADDR != prev_haddr || HTRANS != prev_htrans || HWDATA != prev_hwdata)
        stab_viol = stab_viol + 1;
    end
    if (HRESETN && !HREADY && (HRESP == 2'b01)) begin
      err_seen   = err_seen + 1;
      err_htrans = HTRANS;
    end
    prev_hready = HREADY;
    prev_haddr  = HADDR;
    prev_htrans = HTRANS;
    prev_hwdata = HWDATA;
  end

  // ---------------- checking ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expd);
    n_tests++;
    if (obs !== expd) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, obs, expd);
    end else begin
      $display("[TB] ok   %s: %h", tag, obs);
    end
  endtask

  // Pulse START, then wait (bounded) for DONE, counting BUSY cycles. An
  // optional second START pulse is issued extra_at cycles into the run.
  task automatic run_test(input int extra_at, output int busy_cyc, output int timed_out);
    int k;
    busy_cyc = 0;
    k = 0;
    @(negedge HCLK);
    START = 1'b1;
    @(negedge HCLK);
    START = 1'b0;
    while (!DONE && k < 1000) begin
      if (BUSY) busy_cyc++;
      START = (k == extra_at);
      @(negedge HCLK);
      k++;
    end
    START = 1'b0;
    timed_out = DONE ? 0 : 1;
  endtask

  logic [31:0] exp_wd [4] = '{32'hA5A50001, 32'hA5A50005, 32'hA5A50009, 32'hA5A5000D};
  int s;
  int w;
  int b;
  int t;
  int es;
  int nrd;
  logic found;

  initial begin
    // ---------------- reset state ----------------
    HRESETN = 1'b0;
    repeat (3) @(negedge HCLK);
    chk("rst_htrans",    32'(HTRANS), 32'h0);
    chk("rst_haddr",     HADDR, 32'h0);
    chk("rst_hwrite",    32'(HWRITE), 32'h0);
    chk("rst_hwdata",    HWDATA, 32'h0);
    chk("rst_busy",      32'(BUSY), 32'h0);
    chk("rst_done",      32'(DONE), 32'h0);
    chk("rst_pass",      32'(PASS), 32'h0);
    chk("rst_bus_err",   32'(BUS_ERR), 32'h0);
    chk("rst_err_count", 32'(ERR_COUNT), 32'h0);
    chk("rst_fail_addr", FAIL_ADDR, 32'h0);
    chk("hsize",         32'(HSIZE), 32'h2);
    chk("hburst",        32'(HBURST), 32'h0);
    HRESETN = 1'b1;
    repeat (2) @(negedge HCLK);

    // ---------------- zero-wait pass ----------------
    s = log_n;
    w = wd_n;
    run_test(-1, b, t);
    chk("zw_timeout", 32'(t), 32'h0);
    chk("zw_busy_cycles", 32'(b), 32'd11);
    chk("zw_addr_phases", 32'(log_n - s), 32'd8);
    for (int i = 0; i < NW; i++) begin
      chk($sformatf("zw_waddr%0d", i), log_addr[s + i], 32'(4 * i));
      chk($sformatf("zw_wflag%0d", i), 32'(log_wr[s + i]), 32'h1);
      chk($sformatf("zw_wdata%0d", i), wd_log[w + i], exp_wd[i]);
      chk($sformatf("zw_raddr%0d", i), log_addr[s + NW + i], 32'(4 * i));
      chk($sformatf("zw_rflag%0d", i), 32'(log_wr[s + NW + i]), 32'h0);
    end
    chk("zw_write_span", 32'(log_cyc[s + 3] - log_cyc[s]), 32'd3);
    chk("zw_read_span",  32'(log_cyc[s + 7] - log_cyc[s + 4]), 32'd3);
    chk("zw_done",      32'(DONE), 32'h1);
    chk("zw_pass",      32'(PASS), 32'h1);
    chk("zw_err_count", 32'(ERR_COUNT), 32'h0);
    chk("zw_bus_err",   32'(BUS_ERR), 32'h0);
    chk("zw_fail_addr", FAIL_ADDR, 32'h0);

    // ---------------- two wait states per transfer ----------------
    wait_states = 2;
    chk_stable  = 1'b1;
    run_test(-1, b, t);
    chk_stable  = 1'b0;
    wait_states = 0;
    chk("ws_timeout", 32'(t), 32'h0);
    chk("ws_busy_cycles", 32'(b), 32'd27);
    chk("ws_stable_violations", 32'(stab_viol), 32'h0);
    chk("ws_pass", 32'(PASS), 32'h1);
    chk("ws_done", 32'(DONE), 32'h1);

    // ---------------- corrupted reads of 0x8 and 0xC ----------------
    corrupt_mask = 16'h000C;
    run_test(-1, b, t);
    corrupt_mask = '0;
    chk("cr_timeout",   32'(t), 32'h0);
    chk("cr_err_count", 32'(ERR_COUNT), 32'd2);
    chk("cr_fail_addr", FAIL_ADDR, 32'h8);
    chk("cr_pass",      32'(PASS), 32'h0);
    chk("cr_done",      32'(DONE), 32'h1);
    chk("cr_bus_err",   32'(BUS_ERR), 32'h0);

    // ---------------- ERROR on write to 0x4 ----------------
    err_en   = 1'b1;
    err_addr = 32'h4;
    es = err_seen;
    s  = log_n;
    run_test(-1, b, t);
    err_en = 1'b0;
    nrd = 0;
    for (int i = s; i < log_n; i++) if (!log_wr[i % 256]) nrd++;
    chk("er_timeout",     32'(t), 32'h0);
    chk("er_err_cycles",  32'(err_seen - es), 32'd1);
    chk("er_htrans_cyc1", 32'(err_htrans), 32'h0);
    chk("er_addr_phases", 32'(log_n - s), 32'd2);
    chk("er_read_phases", 32'(nrd), 32'h0);
    chk("er_bus_err",     32'(BUS_ERR), 32'h1);
    chk("er_done",        32'(DONE), 32'h1);
    chk("er_pass",        32'(PASS), 32'h0);

    // ---------------- reset during READ at word 2 ----------------
    @(negedge HCLK);
    START = 1'b1;
    @(negedge HCLK);
    START = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 200 && !found; k++) begin
      if (HTRANS == 2'b10 && !HWRITE && HADDR == 32'h8) found = 1'b1;
      else @(negedge HCLK);
    end
    chk("rr_reached_read2", 32'(found), 32'h1);
    HRESETN = 1'b0;
    #1;
    chk("rr_htrans", 32'(HTRANS), 32'h0);
    chk("rr_haddr",  HADDR, 32'h0);
    chk("rr_hwrite", 32'(HWRITE), 32'h0);
    chk("rr_hwdata", HWDATA, 32'h0);
    chk("rr_busy",   32'(BUSY), 32'h0);
    chk("rr_done",   32'(DONE), 32'h0);
    repeat (2) @(negedge HCLK);
    HRESETN = 1'b1;
    repeat (3) @(negedge HCLK);
    chk("rr_stays_idle", 32'(BUSY), 32'h0);
    run_test(-1, b, t);
    chk("rr_timeout",     32'(t), 32'h0);
    chk("rr_busy_cycles", 32'(b), 32'd11);
    chk("rr_pass",        32'(PASS), 32'h1);

    // ---------------- START while BUSY is ignored ----------------
    s = log_n;
    run_test(2, b, t);
    chk("sb_timeout",     32'(t), 32'h0);
    chk("sb_busy_cycles", 32'(b), 32'd11);
    chk("sb_addr_phases", 32'(log_n - s), 32'd8);
    chk("sb_pass",        32'(PASS), 32'h1);
    repeat (3) @(negedge HCLK);
    chk("sb_no_restart",  32'(BUSY), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
